main_fsm: RTL and testbench

//   Moore control FSM for the multicycle ARM core. It sequences every instruction

---
 rtl/main_fsm_pkg.sv | 30 +++
 rtl/main_fsm_flopr.sv | 16 +
 rtl/main_fsm.sv | 112 +++++++++++
 tb/tb_main_fsm.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared controller definitions: state codes, datapath mux select codes and opcode classes.
package main_fsm_pkg;

  localparam int STATE_BITS = 4;

  localparam logic [STATE_BITS-1:0] FETCH    = 4'd0;
  localparam logic [STATE_BITS-1:0] DECODE   = 4'd1;
  localparam logic [STATE_BITS-1:0] MEMADR   = 4'd2;
  localparam logic [STATE_BITS-1:0] MEMRD    = 4'd3;
  localparam logic [STATE_BITS-1:0] MEMWB    = 4'd4;
  localparam logic [STATE_BITS-1:0] MEMWR    = 4'd5;
  localparam logic [STATE_BITS-1:0] EXECUTER = 4'd6;
  localparam logic [STATE_BITS-1:0] EXECUTEI = 4'd7;
  localparam logic [STATE_BITS-1:0] ALUWB    = 4'd8;
  localparam logic [STATE_BITS-1:0] BRANCH   = 4'd9;
  localparam logic [STATE_BITS-1:0] UNKNOWN  = 4'd10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;

endpackage

// File: rtl/main_fsm_flopr.sv
// Resettable register: asynchronous active-high reset to zero, loads d every rising clk.
module flopr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/main_fsm.sv
// Moore main FSM of the multicycle ARM controller: sequences fetch/decode/execute/memory/writeback
// and drives the datapath selects plus the pre-CondEx write requests.
module main_fsm
  import main_fsm_pkg::*;
#(
  parameter int STATE_W = STATE_BITS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Op,
  input  logic [5:0]         Funct,
  output logic               IRWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic               NextPC,
  output logic               RegW,
  output logic               MemW,
  output logic               Branch,
  output logic               ALUOp,
  output logic [STATE_W-1:0] State
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] next_state;

  // Only the I and L bits steer the sequence; the rest belong to the ALU decoder.
  logic funct_unused;
  assign funct_unused = ^Funct[4:1];

  // FETCH is code zero, so the flop's zero reset lands directly in FETCH.
  flopr #(.WIDTH(STATE_W)) state_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_state),
    .q     (state)
  );

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_DP:   next_state = Funct[5] ? EXECUTEI : EXECUTER;
          OP_MEM:  next_state = MEMADR;
          OP_B:    next_state = BRANCH;
          default: next_state = UNKNOWN;
        endcase
      end
      MEMADR:   next_state = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  // Spare codes fall through to the all-zero default, same as UNKNOWN.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    ResultSrc = RES_ALUOUT;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    case (state)
      FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        NextPC    = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
      end
      MEMADR: ALUSrcB = SRCB_IMM;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
      end
      MEMWR: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      EXECUTER: ALUOp = 1'b1;
      EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = 1'b1;
      end
      ALUWB: RegW = 1'b1;
      BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
      end
      default: ;
    endcase
  end

  assign State = state;

endmodule

// File: tb/tb_main_fsm.sv
// Bench for main_fsm: directed and random instructions against an instruction-class reference model.
module tb_main_fsm;

  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4;
  localparam int S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9, S_UNK = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       IRWrite, AdrSrc, ALUSrcA, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] State;
  logic [11:0] outs;

  int compared = 0;
  int failed = 0;
  int seq[$];

  main_fsm #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Funct     (Funct),
    .IRWrite   (IRWrite),
    .AdrSrc    (AdrSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .NextPC    (NextPC),
    .RegW      (RegW),
    .MemW      (MemW),
    .Branch    (Branch),
    .ALUOp     (ALUOp),
    .State     (State)
  );

  always #5 clk = ~clk;

  assign outs = {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};

  // Expected output word per state: {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
  function automatic logic [11:0] exp_out(input int s);
    case (s)
      S_FETCH:  return {1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      S_DECODE: return {1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      S_MEMADR: return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      S_MEMRD:  return {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      S_MEMWB:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      S_MEMWR:  return {1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      S_EXECR:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      S_EXECI:  return {1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      S_ALUWB:  return {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      S_BRANCH: return {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default:  return 12'h000;
    endcase
  endfunction

  // Reference: the phase list an instruction walks through, derived from its class.
  task automatic build_seq(input logic [1:0] op, input logic [5:0] funct);
    seq.delete();
    seq.push_back(S_FETCH);
    seq.push_back(S_DECODE);
    if (op == 2'b00) begin
      seq.push_back(funct[5] ? S_EXECI : S_EXECR);
      seq.push_back(S_ALUWB);
    end else if (op == 2'b01) begin
      seq.push_back(S_MEMADR);
      if (funct[0]) begin
        seq.push_back(S_MEMRD);
        seq.push_back(S_MEMWB);
      end else begin
        seq.push_back(S_MEMWR);
      end
    end else if (op == 2'b10) begin
      seq.push_back(S_BRANCH);
    end else begin
      seq.push_back(S_UNK);
    end
  endtask

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    compared++;
    assert (got === want) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Called at a falling edge in FETCH; returns at a falling edge in FETCH.
  task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                           input int abort_at);
    build_seq(op, funct);
    foreach (seq[i]) begin
      if (seq[i] == S_DECODE || seq[i] == S_MEMADR) begin
        Op = op;
        Funct = funct;
      end else begin
        Op = 2'($urandom);
        Funct = 6'($urandom);
      end
      #1;
      check($sformatf("%s state[%0d]", name, i), {8'h00, State}, 12'(seq[i]));
      check($sformatf("%s outs[%0d]", name, i), outs, exp_out(seq[i]));
      if (seq[i] == abort_at) begin
        #1 reset = 1'b1;
        #1;
        check($sformatf("%s reset state", name), {8'h00, State}, 12'(S_FETCH));
        check($sformatf("%s reset IRWrite", name), {11'h0, IRWrite}, 12'h001);
        check($sformatf("%s reset NextPC", name), {11'h0, NextPC}, 12'h001);
        check($sformatf("%s reset RegW", name), {11'h0, RegW}, 12'h000);
        check($sformatf("%s reset outs", name), outs, exp_out(S_FETCH));
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    #1;
    check("por state", {8'h00, State}, 12'(S_FETCH));
    check("por outs", outs, exp_out(S_FETCH));
    reset = 1'b0;

    run_instr("add_reg", 2'b00, 6'b000000, -1);
    run_instr("add_imm", 2'b00, 6'b101000, -1);
    run_instr("ldr", 2'b01, 6'b011001, -1);
    run_instr("str", 2'b01, 6'b011000, -1);
    run_instr("branch", 2'b10, 6'b101010, -1);
    run_instr("illegal", 2'b11, 6'b111111, -1);
    run_instr("ldr_abort", 2'b01, 6'b011001, S_MEMRD);
    run_instr("after_abort", 2'b00, 6'b000100, -1);

    for (int n = 0; n < 40; n++) begin
      run_instr($sformatf("rnd%0d", n), 2'($urandom), 6'($urandom), -1);
    end

    #1;
    check("final state", {8'h00, State}, 12'(S_FETCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
